// File: rtl/defuse_timer_if.sv
// rtl/defuse_timer_if.sv - control and status bundle for the defuse countdown timer
interface defuse_timer_if #(
  parameter int CNT_W = 8
);
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             pause;
  logic             defuse;
  logic [CNT_W-1:0] secs;
  logic             tick;
  logic             running;
  logic             expired;
  logic             defused;

  // game logic side: issues commands, observes status
  modport master (
    output load, load_value, pause, defuse,
    input  secs, tick, running, expired, defused
  );

  // timer side: accepts commands, reports status
  modport slave (
    input  load, load_value, pause, defuse,
    output secs, tick, running, expired, defused
  );
endinterface

// File: rtl/defuse_timer.sv
// rtl/defuse_timer.sv - prescaled seconds countdown with pause, defuse and expiry status
module defuse_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          resetn,
  defuse_timer_if.slave bus
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] SECS_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_EXPIRED,
    S_DEFUSED
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_secs,  w_secs_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic             r_tick,  w_tick_nxt;

  // state and datapath registers; reset drops everything back to idle at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_secs  <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_secs  <= w_secs_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // next-state logic: load overrides everything, then defuse, then pause, then counting
  always_comb begin
    w_state_nxt = r_state;
    w_secs_nxt  = r_secs;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;

    if (bus.load) begin
      w_secs_nxt  = bus.load_value;
      w_presc_nxt = '0;
      w_state_nxt = (bus.load_value != '0) ? S_RUN : S_EXPIRED;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (bus.defuse) begin
            // freeze secs and prescaler where they are; no final tick can slip through
            w_state_nxt = S_DEFUSED;
          end else if (!bus.pause) begin
            if (r_presc == PRESC_MAX) begin
              w_presc_nxt = '0;
              if (r_secs != '0) begin
                w_tick_nxt = 1'b1;
                w_secs_nxt = r_secs - SECS_ONE;
              end
              if (r_secs <= SECS_ONE) begin
                w_state_nxt = S_EXPIRED;
              end
            end else begin
              w_presc_nxt = r_presc + PW'(1);
            end
          end
        end
        S_EXPIRED: begin
          w_secs_nxt = '0;
        end
        default: begin
          // idle and defused simply hold until the next load
        end
      endcase
    end
  end

  assign bus.secs    = r_secs;
  assign bus.tick    = r_tick;
  assign bus.running = (r_state == S_RUN);
  assign bus.expired = (r_state == S_EXPIRED);
  assign bus.defused = (r_state == S_DEFUSED);

endmodule

// File: tb/tb_defuse_timer.sv
// tb/tb_defuse_timer.sv - self-checking bench for defuse_timer with TICK_DIV=4
module tb_defuse_timer;

  localparam int TD = 4;
  localparam int CW = 8;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  defuse_timer_if #(.CNT_W(CW)) bus ();

  defuse_timer #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: 0 idle, 1 run, 2 expired, 3 defused; secs derived from active cycles since load
  int m_mode;
  int m_loadv;
  int m_active;
  int m_secs;
  int m_tick;

  always @(posedge clk or negedge resetn) begin : model
    int a;
    if (!resetn) begin
      m_mode   <= 0;
      m_loadv  <= 0;
      m_active <= 0;
      m_secs   <= 0;
      m_tick   <= 0;
    end else begin
      m_tick <= 0;
      if (bus.load) begin
        m_loadv  <= int'(bus.load_value);
        m_active <= 0;
        m_secs   <= int'(bus.load_value);
        m_mode   <= (bus.load_value != 0) ? 1 : 2;
      end else if (m_mode == 1) begin
        if (bus.defuse) begin
          m_mode <= 3;
        end else if (!bus.pause) begin
          a = m_active + 1;
          m_active <= a;
          if (a % TD == 0) begin
            m_tick <= 1;
            m_secs <= m_loadv - a / TD;
            if (m_loadv - a / TD == 0) m_mode <= 2;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle, away from the active edge, the DUT must agree with the model
  always @(negedge clk) begin
    chk("cyc_secs",    int'(bus.secs),    m_secs);
    chk("cyc_tick",    int'(bus.tick),    m_tick);
    chk("cyc_running", int'(bus.running), int'(m_mode == 1));
    chk("cyc_expired", int'(bus.expired), int'(m_mode == 2));
    chk("cyc_defused", int'(bus.defused), int'(m_mode == 3));
  end

  // load strobe sampled by the next edge; returns just after that edge (offset m=0)
  task automatic do_load(input int v);
    @(negedge clk);
    bus.load       = 1'b1;
    bus.load_value = CW'(v);
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  int ticks[$];
  int nt;

  initial begin
    checks   = 0;
    failures = 0;
    resetn         = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.pause      = 1'b0;
    bus.defuse     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_secs", int'(bus.secs), 0);
    chk("rst_flags", int'({bus.tick, bus.running, bus.expired, bus.defused}), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_running", int'(bus.running), 0);

    // 1: count 3 down to 0
    do_load(3);
    chk("t1_secs0", int'(bus.secs), 3);
    chk("t1_run0", int'(bus.running), 1);
    ticks.delete();
    for (int m = 1; m <= 32; m++) begin
      @(negedge clk);
      if (bus.tick) ticks.push_back(m);
      if (m == 8) chk("t1_secs8", int'(bus.secs), 1);
      if (m == 12) begin
        chk("t1_secs12", int'(bus.secs), 0);
        chk("t1_exp12", int'(bus.expired), 1);
        chk("t1_run12", int'(bus.running), 0);
      end
    end
    chk("t1_nticks", ticks.size(), 3);
    if (ticks.size() == 3) begin
      chk("t1_tick_a", ticks[0], 4);
      chk("t1_tick_b", ticks[1], 8);
      chk("t1_tick_c", ticks[2], 12);
    end

    // 2: pause across offsets 2..7 pushes the first tick to +10
    do_load(5);
    nt = 0;
    for (int m = 1; m <= 10; m++) begin
      bus.pause = (m >= 2 && m <= 7);
      @(negedge clk);
      if (bus.tick && nt == 0) nt = m;
    end
    bus.pause = 1'b0;
    chk("t2_first_tick", nt, 10);
    chk("t2_secs", int'(bus.secs), 4);

    // 3: defuse at +6 freezes secs at 8, reload clears defused
    do_load(9);
    nt = 0;
    for (int m = 1; m <= 26; m++) begin
      bus.defuse = (m == 6);
      @(negedge clk);
      if (m > 6 && bus.tick) nt++;
    end
    bus.defuse = 1'b0;
    chk("t3_defused", int'(bus.defused), 1);
    chk("t3_secs", int'(bus.secs), 8);
    chk("t3_ticks_after", nt, 0);
    do_load(2);
    chk("t3_reload_def", int'(bus.defused), 0);
    chk("t3_reload_run", int'(bus.running), 1);
    repeat (12) @(negedge clk);

    // 4: defuse coincident with the final tick wins
    do_load(1);
    for (int m = 1; m <= 4; m++) begin
      bus.defuse = (m == 4);
      @(negedge clk);
    end
    bus.defuse = 1'b0;
    chk("t4_defused", int'(bus.defused), 1);
    chk("t4_secs", int'(bus.secs), 1);
    chk("t4_expired", int'(bus.expired), 0);
    chk("t4_tick", int'(bus.tick), 0);
    repeat (6) @(negedge clk);

    // 5: load of zero expires at once without a tick
    do_load(0);
    chk("t5_expired", int'(bus.expired), 1);
    chk("t5_secs", int'(bus.secs), 0);
    nt = 0;
    for (int m = 1; m <= 10; m++) begin
      bus.pause  = (m[0] == 1'b1);
      bus.defuse = (m == 3);
      @(negedge clk);
      if (bus.tick) nt++;
    end
    bus.pause  = 1'b0;
    bus.defuse = 1'b0;
    chk("t5_ticks", nt, 0);
    chk("t5_still_exp", int'(bus.expired), 1);

    // 6: asynchronous reset between edges mid-count
    do_load(200);
    repeat (9) @(negedge clk);
    chk("t6_secs_pre", int'(bus.secs), 198);
    #1 resetn = 1'b0;
    #1;
    chk("t6_secs_rst", int'(bus.secs), 0);
    chk("t6_flags_rst", int'({bus.tick, bus.running, bus.expired, bus.defused}), 0);
    @(negedge clk);
    resetn = 1'b1;
    do_load(7);
    chk("t6_reload_secs", int'(bus.secs), 7);
    chk("t6_reload_run", int'(bus.running), 1);
    repeat (4) @(negedge clk);
    chk("t6_reload_tick_secs", int'(bus.secs), 6);

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
